// File: rtl/pixel_frame_buffer_pkg.sv
// Shared sizing, FSM encoding and helpers for the HUB75 double-buffered pixel store.
// The swap-state encoding is shared with the scan controller's package.
package pixel_frame_buffer_pkg;

    localparam int DEF_SCREEN_WIDTH = 32;
    localparam int DEF_SCREEN_DEPTH = 16;
    localparam int DEF_COLOR_DEPTH  = 1;
    localparam int COORD_W          = 6;
    localparam int DEF_ADDR_W       = $clog2(2 * DEF_SCREEN_WIDTH * DEF_SCREEN_DEPTH);

    typedef enum logic {
        FB_IDLE    = 1'b0,
        FB_PENDING = 1'b1
    } fb_state_e;

    function automatic int plane_w(input int color_depth);
        return (color_depth > 1) ? $clog2(color_depth) : 1;
    endfunction

endpackage

// File: rtl/pixel_frame_buffer_fb_dpram.sv
// Two-bank pixel RAM: one write port, two synchronous read ports (top and bottom half).
// No reset on the array so it maps onto block RAM.
module fb_dpram
    import pixel_frame_buffer_pkg::*;
#(
    parameter int DATA_W = 3,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int WORDS  = 2 * DEF_SCREEN_WIDTH * DEF_SCREEN_DEPTH
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_a_i,
    input  logic [ADDR_W-1:0] raddr_b_i,
    output logic [DATA_W-1:0] rdata_a_o,
    output logic [DATA_W-1:0] rdata_b_o
);

    logic [DATA_W-1:0] mem_q [WORDS];
    logic [DATA_W-1:0] rdata_a_q;
    logic [DATA_W-1:0] rdata_b_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_a_q <= mem_q[raddr_a_i];
        rdata_b_q <= mem_q[raddr_b_i];
    end

    assign rdata_a_o = rdata_a_q;
    assign rdata_b_o = rdata_b_q;

endmodule

// File: rtl/pixel_frame_buffer.sv
// Double-buffered HUB75 pixel store; bank swaps wait for the scan controller's frame start.
//   state   | meaning
//   IDLE    | writes accepted, no swap outstanding
//   PENDING | swap requested, writes stalled until frame_start
module pixel_frame_buffer
    import pixel_frame_buffer_pkg::*;
#(
    parameter int SCREEN_WIDTH = DEF_SCREEN_WIDTH,
    parameter int SCREEN_DEPTH = DEF_SCREEN_DEPTH,
    parameter int COLOR_DEPTH  = DEF_COLOR_DEPTH
) (
    input  logic                           clk_in,
    input  logic                           rst_n,
    input  logic                           wr_valid,
    output logic                           wr_ready,
    input  logic [COORD_W-1:0]             wr_x,
    input  logic [COORD_W-1:0]             wr_y,
    input  logic [3*COLOR_DEPTH-1:0]       wr_rgb,
    input  logic                           swap_req,
    output logic                           swap_ack,
    input  logic                           frame_start,
    input  logic [COORD_W-1:0]             rd_row,
    input  logic [COORD_W-1:0]             rd_col,
    input  logic [plane_w(COLOR_DEPTH)-1:0] rd_plane,
    output logic                           R1_data,
    output logic                           G1_data,
    output logic                           B1_data,
    output logic                           R2_data,
    output logic                           G2_data,
    output logic                           B2_data
);

    localparam int PIX_W   = 3 * COLOR_DEPTH;
    localparam int PLANE_W = plane_w(COLOR_DEPTH);
    localparam int HALF    = SCREEN_DEPTH / 2;
    localparam int BANK_SZ = SCREEN_WIDTH * SCREEN_DEPTH;
    localparam int WORDS   = 2 * BANK_SZ;
    localparam int ADDR_W  = $clog2(WORDS);

    fb_state_e state_q, state_d;
    logic      front_q, front_d;
    logic      ack_q, ack_d;
    logic      rdy_en_q;
    logic      back_bank;

    always_comb begin
        state_d = state_q;
        front_d = front_q;
        ack_d   = 1'b0;
        case (state_q)
            FB_IDLE: begin
                if (swap_req) begin
                    state_d = FB_PENDING;
                end
            end
            FB_PENDING: begin
                if (frame_start) begin
                    front_d = ~front_q;
                    ack_d   = 1'b1;
                    state_d = FB_IDLE;
                end
            end
            default: state_d = FB_IDLE;
        endcase
    end

    // rdy_en_q holds wr_ready low until the first edge after reset release.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FB_IDLE;
            front_q  <= 1'b0;
            ack_q    <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            front_q  <= front_d;
            ack_q    <= ack_d;
            rdy_en_q <= 1'b1;
        end
    end

    assign wr_ready  = rdy_en_q && (state_q == FB_IDLE);
    assign swap_ack  = ack_q;
    assign back_bank = ~front_q;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr_top;
    logic [ADDR_W-1:0] rd_addr_bot;
    logic [PIX_W-1:0]  pix_top;
    logic [PIX_W-1:0]  pix_bot;

    // Out-of-range beats still complete the handshake but never reach the RAM.
    assign wr_en   = wr_valid && wr_ready
                     && (32'(wr_x) < SCREEN_WIDTH) && (32'(wr_y) < SCREEN_DEPTH);
    assign wr_addr = ADDR_W'(32'(back_bank) * BANK_SZ + 32'(wr_y) * SCREEN_WIDTH + 32'(wr_x));

    assign rd_addr_top = ADDR_W'(32'(front_q) * BANK_SZ
                                 + 32'(rd_row) * SCREEN_WIDTH + 32'(rd_col));
    assign rd_addr_bot = ADDR_W'(32'(front_q) * BANK_SZ
                                 + (32'(rd_row) + HALF) * SCREEN_WIDTH + 32'(rd_col));

    fb_dpram #(
        .DATA_W (PIX_W),
        .ADDR_W (ADDR_W),
        .WORDS  (WORDS)
    ) u_ram (
        .clk_i     (clk_in),
        .we_i      (wr_en),
        .waddr_i   (wr_addr),
        .wdata_i   (wr_rgb),
        .raddr_a_i (rd_addr_top),
        .raddr_b_i (rd_addr_bot),
        .rdata_a_o (pix_top),
        .rdata_b_o (pix_bot)
    );

    logic               rd_ok_q;
    logic [PLANE_W-1:0] plane_q;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            rd_ok_q <= 1'b0;
            plane_q <= '0;
        end else begin
            rd_ok_q <= (32'(rd_row) < HALF) && (32'(rd_col) < SCREEN_WIDTH)
                       && (32'(rd_plane) < COLOR_DEPTH);
            plane_q <= rd_plane;
        end
    end

    logic [COLOR_DEPTH-1:0] r1_sh, g1_sh, b1_sh, r2_sh, g2_sh, b2_sh;

    assign r1_sh = pix_top[3*COLOR_DEPTH-1 -: COLOR_DEPTH] >> plane_q;
    assign g1_sh = pix_top[2*COLOR_DEPTH-1 -: COLOR_DEPTH] >> plane_q;
    assign b1_sh = pix_top[COLOR_DEPTH-1   -: COLOR_DEPTH] >> plane_q;
    assign r2_sh = pix_bot[3*COLOR_DEPTH-1 -: COLOR_DEPTH] >> plane_q;
    assign g2_sh = pix_bot[2*COLOR_DEPTH-1 -: COLOR_DEPTH] >> plane_q;
    assign b2_sh = pix_bot[COLOR_DEPTH-1   -: COLOR_DEPTH] >> plane_q;

    assign R1_data = rd_ok_q & r1_sh[0];
    assign G1_data = rd_ok_q & g1_sh[0];
    assign B1_data = rd_ok_q & b1_sh[0];
    assign R2_data = rd_ok_q & r2_sh[0];
    assign G2_data = rd_ok_q & g2_sh[0];
    assign B2_data = rd_ok_q & b2_sh[0];

endmodule

// File: tb/tb_pixel_frame_buffer.sv
// Directed bench for pixel_frame_buffer: default 1-bit colour instance plus a 4-bit colour instance.
module tb_pixel_frame_buffer;

    typedef struct {
        logic [5:0] row;
        logic [5:0] col;
        logic [1:0] pl;
        logic [5:0] exp;
        string      name;
    } rd_vec_t;

    int checks   = 0;
    int failures = 0;

    logic clk_in = 1'b0;
    logic rst_n  = 1'b0;
    always #5 clk_in = ~clk_in;

    logic       a_wr_valid = 0, a_wr_ready, a_swap_req = 0, a_swap_ack, a_frame_start = 0;
    logic [5:0] a_wr_x = 0, a_wr_y = 0, a_rd_row = 0, a_rd_col = 0;
    logic [2:0] a_wr_rgb = 0;
    logic       a_rd_plane = 0;
    logic       a_r1, a_g1, a_b1, a_r2, a_g2, a_b2;

    logic       b_wr_valid = 0, b_wr_ready, b_swap_req = 0, b_swap_ack, b_frame_start = 0;
    logic [5:0] b_wr_x = 0, b_wr_y = 0, b_rd_row = 0, b_rd_col = 0;
    logic [11:0] b_wr_rgb = 0;
    logic [1:0] b_rd_plane = 0;
    logic       b_r1, b_g1, b_b1, b_r2, b_g2, b_b2;

    pixel_frame_buffer dut_a (
        .clk_in(clk_in), .rst_n(rst_n),
        .wr_valid(a_wr_valid), .wr_ready(a_wr_ready), .wr_x(a_wr_x), .wr_y(a_wr_y),
        .wr_rgb(a_wr_rgb), .swap_req(a_swap_req), .swap_ack(a_swap_ack),
        .frame_start(a_frame_start), .rd_row(a_rd_row), .rd_col(a_rd_col),
        .rd_plane(a_rd_plane),
        .R1_data(a_r1), .G1_data(a_g1), .B1_data(a_b1),
        .R2_data(a_r2), .G2_data(a_g2), .B2_data(a_b2)
    );

    pixel_frame_buffer #(.COLOR_DEPTH(4)) dut_b (
        .clk_in(clk_in), .rst_n(rst_n),
        .wr_valid(b_wr_valid), .wr_ready(b_wr_ready), .wr_x(b_wr_x), .wr_y(b_wr_y),
        .wr_rgb(b_wr_rgb), .swap_req(b_swap_req), .swap_ack(b_swap_ack),
        .frame_start(b_frame_start), .rd_row(b_rd_row), .rd_col(b_rd_col),
        .rd_plane(b_rd_plane),
        .R1_data(b_r1), .G1_data(b_g1), .B1_data(b_b1),
        .R2_data(b_r2), .G2_data(b_g2), .B2_data(b_b2)
    );

    wire [5:0] a_rd6 = {a_r1, a_g1, a_b1, a_r2, a_g2, a_b2};
    wire [5:0] b_rd6 = {b_r1, b_g1, b_b1, b_r2, b_g2, b_b2};

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic write_a(input logic [5:0] x, input logic [5:0] y, input logic [2:0] rgb);
        a_wr_valid = 1; a_wr_x = x; a_wr_y = y; a_wr_rgb = rgb;
        chk("a_wr_ready", a_wr_ready, 1);
        tick();
        a_wr_valid = 0;
    endtask

    task automatic write_b(input logic [5:0] x, input logic [5:0] y, input logic [11:0] rgb);
        b_wr_valid = 1; b_wr_x = x; b_wr_y = y; b_wr_rgb = rgb;
        chk("b_wr_ready", b_wr_ready, 1);
        tick();
        b_wr_valid = 0;
    endtask

    task automatic read_a(input logic [5:0] row, input logic [5:0] col, input logic pl,
                          input logic [5:0] exp, input string name);
        a_rd_row = row; a_rd_col = col; a_rd_plane = pl;
        tick();
        chk(name, a_rd6, exp);
    endtask

    task automatic swap_a();
        a_swap_req = 1; tick(); a_swap_req = 0;
        chk("a_pending_ready", a_wr_ready, 0);
        tick();
        chk("a_pending_noack", a_swap_ack, 0);
        a_frame_start = 1; tick(); a_frame_start = 0;
        chk("a_swap_ack", a_swap_ack, 1);
        chk("a_ready_after_swap", a_wr_ready, 1);
        tick();
        chk("a_ack_single", a_swap_ack, 0);
    endtask

    rd_vec_t tab_a[7];
    rd_vec_t tab_b[6];

    initial begin
        tab_a[0] = '{6'd0, 6'd0,  2'd0, 6'b100001, "rd_r0c0"};
        tab_a[1] = '{6'd1, 6'd3,  2'd0, 6'b010110, "rd_r1c3"};
        tab_a[2] = '{6'd2, 6'd5,  2'd0, 6'b000000, "rd_back_hidden"};
        tab_a[3] = '{6'd8, 6'd0,  2'd0, 6'b000000, "rd_row_oor"};
        tab_a[4] = '{6'd0, 6'd32, 2'd0, 6'b000000, "rd_col_oor"};
        tab_a[5] = '{6'd0, 6'd0,  2'd1, 6'b000000, "rd_plane_oor"};
        tab_a[6] = '{6'd1, 6'd3,  2'd1, 6'b000000, "rd_plane_oor2"};

        tab_b[0] = '{6'd0, 6'd0, 2'd0, 6'b000000, "b_plane0"};
        tab_b[1] = '{6'd0, 6'd0, 2'd1, 6'b100000, "b_plane1"};
        tab_b[2] = '{6'd0, 6'd0, 2'd2, 6'b000000, "b_plane2"};
        tab_b[3] = '{6'd0, 6'd0, 2'd3, 6'b100000, "b_plane3"};
        tab_b[4] = '{6'd0, 6'd1, 2'd1, 6'b010000, "b_g_plane1"};
        tab_b[5] = '{6'd0, 6'd1, 2'd3, 6'b000000, "b_g_plane3"};

        // Reset state
        tick();
        chk("rst_wr_ready", a_wr_ready, 0);
        chk("rst_swap_ack", a_swap_ack, 0);
        chk("rst_data", a_rd6, 0);
        rst_n = 1;
        #2;
        chk("rel_wr_ready_before_edge", a_wr_ready, 0);
        tick();
        chk("rel_wr_ready", a_wr_ready, 1);

        // Fill bank 1 (back) and swap it to the front
        write_a(0, 0, 3'b100);
        write_a(0, 8, 3'b001);
        write_a(3, 1, 3'b010);
        write_a(3, 9, 3'b110);
        write_a(5, 2, 3'b000);
        write_a(5, 10, 3'b000);
        swap_a();

        // Bank 0 is now the back bank
        write_a(5, 2, 3'b111);
        write_a(5, 10, 3'b111);
        write_a(0, 1, 3'b000);
        write_a(0, 9, 3'b000);
        write_a(32, 0, 3'b111);
        write_a(0, 16, 3'b111);

        for (int i = 0; i < 7; i++) begin
            read_a(tab_a[i].row, tab_a[i].col, tab_a[i].pl[0], tab_a[i].exp, tab_a[i].name);
        end

        // swap_req coinciding with frame_start and an accepted write
        write_a(7, 11, 3'b010);
        a_swap_req = 1; a_frame_start = 1;
        a_wr_valid = 1; a_wr_x = 7; a_wr_y = 3; a_wr_rgb = 3'b101;
        chk("a_same_cycle_ready", a_wr_ready, 1);
        tick();
        a_swap_req = 0; a_frame_start = 0; a_wr_valid = 0;
        chk("a_same_cycle_noack", a_swap_ack, 0);
        chk("a_same_cycle_pending", a_wr_ready, 0);
        tick();
        chk("a_same_cycle_noack2", a_swap_ack, 0);
        chk("a_same_cycle_pending2", a_wr_ready, 0);
        a_frame_start = 1; tick(); a_frame_start = 0;
        chk("a_second_fs_ack", a_swap_ack, 1);
        chk("a_second_fs_ready", a_wr_ready, 1);
        tick();
        chk("a_second_fs_ack_drop", a_swap_ack, 0);
        read_a(2, 5, 0, 6'b111111, "rd_bank0_r2c5");
        read_a(1, 0, 0, 6'b000000, "rd_oor_write_dropped");
        read_a(3, 7, 0, 6'b101010, "rd_swap_cycle_write");

        // Back to bank 1, then reset while a swap is pending
        swap_a();
        read_a(0, 0, 0, 6'b100001, "rd_bank1_again");
        a_swap_req = 1; tick(); a_swap_req = 0;
        chk("a_pre_rst_pending", a_wr_ready, 0);
        rst_n = 0;
        #1;
        chk("a_rst_ack", a_swap_ack, 0);
        chk("a_rst_ready", a_wr_ready, 0);
        chk("a_rst_data", a_rd6, 0);
        tick();
        tick();
        rst_n = 1;
        tick();
        chk("a_post_rst_ready", a_wr_ready, 1);
        a_frame_start = 1; a_rd_row = 2; a_rd_col = 5; a_rd_plane = 0;
        tick();
        a_frame_start = 0;
        chk("a_post_rst_noack", a_swap_ack, 0);
        chk("a_post_rst_front0", a_rd6, 6'b111111);
        tick();
        chk("a_post_rst_noack2", a_swap_ack, 0);

        // 4-bit colour instance: plane selection
        write_b(0, 0, 12'hA00);
        write_b(0, 8, 12'h000);
        write_b(1, 0, 12'h060);
        write_b(1, 8, 12'h000);
        b_swap_req = 1; tick(); b_swap_req = 0;
        chk("b_pending_ready", b_wr_ready, 0);
        b_frame_start = 1; tick(); b_frame_start = 0;
        chk("b_swap_ack", b_swap_ack, 1);
        for (int i = 0; i < 6; i++) begin
            b_rd_row = tab_b[i].row; b_rd_col = tab_b[i].col; b_rd_plane = tab_b[i].pl;
            tick();
            chk(tab_b[i].name, b_rd6, tab_b[i].exp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pixel_frame_buffer.md
# pixel_frame_buffer

Double-buffered pixel store sitting directly upstream of the HUB75 scan controller. A host-side writer loads pixels into the back bank through a valid/ready port. The scan controller reads the front bank by row, column and bit-plane, and gets the top-half and bottom-half RGB bits it shifts out. Bank swaps are requested by the writer and take effect only at a frame boundary signalled by the scan controller, so a frame is never torn.

## Interface
- SCREEN_WIDTH, 32, columns per row
- SCREEN_DEPTH, 16, total rows; must be even, rows 0..DEPTH/2-1 are the top half
- COLOR_DEPTH, 1, bits per colour channel; a pixel is 3*COLOR_DEPTH bits, packed {R,G,B}, MSB = plane COLOR_DEPTH-1
- Ports:
  - clk_in  in  1  sole clock
  - rst_n  in  1  asynchronous active-low reset
  - wr_valid  in  1  write request
  - wr_ready  out  1  write accepted when wr_valid && wr_ready
  - wr_x  in  6  column
  - wr_y  in  6  row, 0..SCREEN_DEPTH-1
  - wr_rgb  in  3*COLOR_DEPTH  pixel value
  - swap_req  in  1  single-cycle pulse requesting a bank swap
  - swap_ack  out  1  single-cycle pulse when the swap is done
  - frame_start  in  1  single-cycle pulse from the scan controller at its row-0 SDI entry
  - rd_row  in  6  half-panel row, 0..SCREEN_DEPTH/2-1
  - rd_col  in  6  column
  - rd_plane  in  clog2(COLOR_DEPTH), min 1  bit-plane select
  - R1_data, G1_data, B1_data  out  1 each  top pixel (rd_row, rd_col) plane bits
  - R2_data, G2_data, B2_data  out  1 each  bottom pixel (rd_row+DEPTH/2, rd_col) plane bits

## Operation
- Storage: 2 banks × SCREEN_WIDTH×SCREEN_DEPTH entries. `front` (1 bit) selects the read bank; writes go to the ~front bank. Memory contents are not reset.
- Write: on an accepted beat, wr_rgb is stored at (~front, wr_y, wr_x). If wr_x ≥ WIDTH or wr_y ≥ DEPTH, the beat is accepted (handshake completes) but nothing is written.
- Swap FSM, states IDLE and PENDING:
  - IDLE: wr_ready=1. swap_req → PENDING.
  - PENDING: wr_ready=0. frame_start → toggle front, pulse swap_ack, then IDLE. swap_req is ignored.
  - swap_req and frame_start in the same IDLE cycle → PENDING only. The swap waits for the next frame_start.
  - A write accepted in the same cycle as swap_req lands in the old back bank, which becomes visible after the swap.
- Read: every cycle, rd_row/rd_col/rd_plane are sampled. Top and bottom pixels are fetched from the front bank, and bit rd_plane of each channel is registered onto the outputs. If rd_row ≥ DEPTH/2, rd_col ≥ WIDTH, or rd_plane ≥ COLOR_DEPTH, the outputs are all 0.
- frame_start in IDLE has no effect.

## Timing
- Reset values: wr_ready=0 while rst_n is low and 1 from the first clk_in edge after release. swap_ack=0, all six data outputs 0, front=0, FSM=IDLE.
- Read latency: 1 cycle, address at edge N → data valid after edge N+1. Throughput is one read per cycle.
- Write: takes effect at the accepting edge. A read of the same address from the same bank in the next cycle sees the new value. Reads never target the back bank except across a swap.
- Swap: front toggles at the frame_start edge while in PENDING. Reads issued from the next cycle use the new bank. swap_ack is high for exactly the cycle after that edge. wr_ready returns to 1 in the same cycle.
- Reset asserted mid-PENDING: FSM → IDLE, front=0, no swap_ack.

## Structure
- Shared package:
  - SCREEN_WIDTH/SCREEN_DEPTH/COLOR_DEPTH defaults
  - address width localparams
  - FSM state encodings (IDLE=0, PENDING=1), shared with the scan controller's package
- Sub-module fb_dpram: one write port, two synchronous read ports (top and bottom).
  - Address is {bank, row, col}, flattened as bank*WIDTH*DEPTH + row*WIDTH + col.
  - Infers block RAM, no reset on the array.
- pixel_frame_buffer holds the FSM, the front bit, range checks and plane-select muxing.

## Test plan
- Reset then write (0,0)=3'b100 and (0,8)=3'b001 with defaults, swap_req, then frame_start. Expect swap_ack 1 cycle later. Read row 0 col 0 → R1=1, B2=1, all others 0, on the edge after the address.
- Write to the back bank without swapping, then read the same address → front contents (0) unchanged.
- swap_req and frame_start in the same cycle → no ack. A second frame_start → ack and front=1. wr_ready is low throughout the pending cycles.
- Write (32,0) and (0,16) → both accepted, no memory change. Read rd_row=8 → outputs 0.
- COLOR_DEPTH=4: write pixel R=4'b1010. Planes 0..3 read R1 = 0,1,0,1.
- Assert rst_n low while in PENDING → after release front=0, FSM IDLE, and the next frame_start produces no ack.
